// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller, 8x oversampling.
// Detects the start bit, runs the edge counter for the majority-vote sampler,
// assembles an LSB-first data word, checks optional parity and the stop bit,
// and publishes a validated byte with a one-cycle data_valid pulse.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [2:0]            edge_cnt,
    output logic                  dat_samp_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q, par_typ_q;
    logic                  last_edge, last_bit;

    // Every decision happens on the final oversampling edge of a bit.
    assign last_edge   = (edge_cnt == 3'd7);
    assign last_bit    = (bit_cnt == 4'(DATA_WIDTH - 1));
    assign dat_samp_en = (state != IDLE);

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; non-IDLE states advance only on edge 7.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!RX_IN) state_nxt = START;
            START:   if (last_edge) state_nxt = sampled_bit ? IDLE : DATA;
            DATA:    if (last_edge && last_bit) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (last_edge) state_nxt = STOP;
            STOP:    if (last_edge) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Edge counter, data assembly, error flags and output word.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt   <= 3'd0;
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            // Wrapping 7->0 lines the counter up with the next bit on state change.
            if (state == IDLE) edge_cnt <= 3'd0;
            else               edge_cnt <= edge_cnt + 3'd1;

            case (state)
                IDLE: begin
                    // Frame options are frozen at start so mid-frame changes are ignored.
                    if (!RX_IN) begin
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_err   <= 1'b0;
                        stp_err   <= 1'b0;
                    end
                end
                START: begin
                    if (last_edge) bit_cnt <= 4'd0;
                end
                DATA: begin
                    if (last_edge) begin
                        for (int i = 0; i < DATA_WIDTH; i++)
                            if (bit_cnt == 4'(i)) shreg[i] <= sampled_bit;
                        if (!last_bit) bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    if (last_edge) par_err <= sampled_bit ^ (^shreg) ^ par_typ_q;
                end
                STOP: begin
                    if (last_edge) begin
                        stp_err <= ~sampled_bit;
                        if (sampled_bit && !par_err) begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a behavioural 3-sample
// majority-vote sampling stage (edges 1..3) feeding sampled_bit.
module tb_uart_rx_frame_ctrl;

    logic       CLK, RST, RX_IN, sampled_bit, PAR_EN, PAR_TYP;
    logic [2:0] edge_cnt;
    logic       dat_samp_en, data_valid, par_err, stp_err;
    logic [7:0] P_DATA;

    int vecs = 0;
    int errs = 0;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .sampled_bit(sampled_bit),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .edge_cnt(edge_cnt),
        .dat_samp_en(dat_samp_en), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sampling stage model: capture RX_IN at edges 1..3, majority vote.
    logic s0 = 1'b1, s1 = 1'b1, s2 = 1'b1;
    always @(posedge CLK) begin
        if (dat_samp_en) begin
            case (edge_cnt)
                3'd1: s0 <= RX_IN;
                3'd2: s1 <= RX_IN;
                3'd3: s2 <= RX_IN;
                default: ;
            endcase
        end
    end
    assign sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);

    // Monitor on the falling edge: cycle count, frame start, data_valid pulses.
    int         cyc = 0;
    int         en_cyc = 0, dv_cyc = 0, dv_cnt = 0;
    logic       prev_en = 1'b0;
    logic [7:0] dv_hist[$];
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (dat_samp_en && !prev_en) en_cyc = cyc;
        prev_en = dat_samp_en;
        if (data_valid) begin
            dv_cnt++;
            dv_cyc = cyc;
            dv_hist.push_back(P_DATA);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (8) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Start, 8 data bits LSB first, optional parity, stop. flip toggles the
    // parity controls after the start bit to show they are latched.
    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit,
                              input logic flip);
        logic pe, pt;
        pe = PAR_EN;
        pt = PAR_TYP;
        drive_bit(1'b0);
        if (flip) begin
            PAR_EN  = ~pe;
            PAR_TYP = ~pt;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (has_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        PAR_EN  = pe;
        PAR_TYP = pt;
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #2;
        chk("rst_edge_cnt", 32'(edge_cnt), 0);
        chk("rst_samp_en",  32'(dat_samp_en), 0);
        chk("rst_p_data",   32'(P_DATA), 0);
        chk("rst_dv",       32'(data_valid), 0);
        chk("rst_par_err",  32'(par_err), 0);
        chk("rst_stp_err",  32'(stp_err), 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        idle(3);

        // 0xA5, no parity.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("a5_dv_cnt",  32'(dv_cnt), 1);
        chk("a5_p_data",  32'(P_DATA), 32'hA5);
        chk("a5_latency", 32'(dv_cyc - en_cyc), 80);
        chk("a5_par_err", 32'(par_err), 0);
        chk("a5_stp_err", 32'(stp_err), 0);
        chk("a5_idle_en", 32'(dat_samp_en), 0);

        // 0x3C, even parity, good then bad parity bit.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("3c_dv_cnt",  32'(dv_cnt), 2);
        chk("3c_p_data",  32'(P_DATA), 32'h3C);
        chk("3c_par_err", 32'(par_err), 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("3c_bad_dv_cnt",  32'(dv_cnt), 2);
        chk("3c_bad_p_data",  32'(P_DATA), 32'h3C);
        chk("3c_bad_par_err", 32'(par_err), 1);

        // 0x81, odd parity, controls flipped mid-frame; then bad stop bit.
        PAR_TYP = 1'b1;
        send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("81_dv_cnt",  32'(dv_cnt), 3);
        chk("81_p_data",  32'(P_DATA), 32'h81);
        chk("81_par_err", 32'(par_err), 0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("81_stp_dv_cnt",  32'(dv_cnt), 3);
        chk("81_stp_p_data",  32'(P_DATA), 32'h81);
        chk("81_stp_err",     32'(stp_err), 1);
        idle(10);
        chk("81_stp_sticky",  32'(stp_err), 1);

        // Two-cycle glitch: START rejects it, flags cleared by start detect.
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("gl_samp_en",  32'(dat_samp_en), 1);
        chk("gl_edge_cnt", 32'(edge_cnt), 1);
        idle(12);
        chk("gl_samp_off", 32'(dat_samp_en), 0);
        chk("gl_edge_0",   32'(edge_cnt), 0);
        chk("gl_stp_err",  32'(stp_err), 0);
        chk("gl_par_err",  32'(par_err), 0);
        chk("gl_dv_cnt",   32'(dv_cnt), 3);
        chk("gl_p_data",   32'(P_DATA), 32'h81);

        // Bad-parity frame, then 0x55/0xAA back to back with no parity.
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("pre_b2b_par_err", 32'(par_err), 1);
        PAR_EN = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("b2b_dv_cnt",  32'(dv_cnt), 5);
        chk("b2b_first",   32'(dv_hist[3]), 32'h55);
        chk("b2b_second",  32'(dv_hist[4]), 32'hAA);
        chk("b2b_p_data",  32'(P_DATA), 32'hAA);
        chk("b2b_par_err", 32'(par_err), 0);

        // Reset in the middle of data bit 4, then a clean 0x0F.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        RX_IN = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        chk("mid_rst_p_data",   32'(P_DATA), 0);
        chk("mid_rst_edge_cnt", 32'(edge_cnt), 0);
        chk("mid_rst_samp_en",  32'(dat_samp_en), 0);
        chk("mid_rst_dv",       32'(data_valid), 0);
        idle(3);
        RST = 1'b1;
        idle(3);
        chk("mid_rst_no_dv", 32'(dv_cnt), 5);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        chk("0f_dv_cnt",  32'(dv_cnt), 6);
        chk("0f_p_data",  32'(P_DATA), 32'h0F);
        chk("0f_stp_err", 32'(stp_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame controller for the UART RX path, fixed at 8x oversampling. It detects the start bit and runs the 3-bit edge counter that drives the majority-vote sampling stage (edge_cnt, dat_samp_en). It consumes that stage's sampled_bit, assembles the LSB-first data word, checks optional parity and the stop bit, and reports a validated parallel byte to the RX output / SYS_CTRL side.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (1..8; bit counter is 4 bits)

Ports:
CLK  input  1  system/RX clock, 8 cycles per bit period
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
sampled_bit  input  1  majority-voted bit from the sampling stage; valid while edge_cnt==7
PAR_EN  input  1  1 = parity bit present after data
PAR_TYP  input  1  0 = even parity, 1 = odd parity
edge_cnt  output  3  oversampling edge index 0..7 within the current bit
dat_samp_en  output  1  sampling-stage enable, high whenever state != IDLE
P_DATA  output  DATA_WIDTH  last accepted data word
data_valid  output  1  one-cycle pulse when P_DATA is updated
par_err  output  1  parity mismatch on last frame, sticky until next start
stp_err  output  1  stop bit sampled low on last frame, sticky until next start

Behaviour:
- Reset is asynchronous, active-low. While RST is low: state=IDLE, edge_cnt=0, bit_cnt=0, shift register=0, P_DATA=0, data_valid=0, par_err=0, stp_err=0, latched PAR_EN/PAR_TYP=0. A reset mid-frame abandons the frame and produces no data_valid.
- States: IDLE, START, DATA, PARITY, STOP. All are registered.
- IDLE: edge_cnt held at 0. When RX_IN==0 is sampled, go to START on the next edge. On that same edge, latch PAR_EN and PAR_TYP and clear par_err and stp_err.
- In every non-IDLE state, edge_cnt increments by 1 each cycle and wraps 7->0. Each bit therefore occupies exactly 8 cycles, starting at edge_cnt=0 on entry.
- All decisions are taken in the cycle where edge_cnt==7, using sampled_bit:
  - START: sampled_bit==1 means a glitch; return to IDLE with no flags and no data_valid. Otherwise go to DATA with bit_cnt=0.
  - DATA: write sampled_bit into shift register bit [bit_cnt] (LSB first). If bit_cnt==DATA_WIDTH-1, go to PARITY when latched PAR_EN=1, else go to STOP. Otherwise increment bit_cnt.
  - PARITY: expected = XOR of the shift register, inverted when PAR_TYP=1. par_err <= (sampled_bit != expected). Go to STOP.
  - STOP: stp_err <= ~sampled_bit. If sampled_bit==1 and par_err==0, then P_DATA <= shift register and data_valid=1 for exactly the next cycle. Go to IDLE.
- Failed-frame rules: on a parity or stop error, P_DATA keeps its previous value and data_valid stays low. The error flags remain set until the next start detection.
- Latency: data_valid rises on the clock edge ending the STOP bit's edge_cnt==7 cycle, and is high for one cycle.
- Back-to-back frames: the IDLE cycle after STOP re-checks RX_IN. This gives a 1-cycle slip per frame, which is tolerated by sampling at edges 1..3.
- Input stability: PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- RX_IN is already synchronised upstream; this block performs no synchronisation.

Test Plan:
- 0xA5, PAR_EN=0, 8 cycles/bit, real sampling stage in the bench -> data_valid pulses once, 1 cycle after stop edge 7 (80 cycles after start detect). P_DATA=0xA5, par_err=0, stp_err=0.
- 0x3C, PAR_EN=1, PAR_TYP=0, parity bit 0 -> P_DATA=0x3C, data_valid=1. Repeat with the parity bit driven 1 -> par_err=1, no data_valid, P_DATA unchanged.
- 0x81, PAR_EN=1, PAR_TYP=1, correct odd parity bit 1 -> P_DATA=0x81. Repeat with the stop bit driven 0 -> stp_err=1, data_valid stays 0.
- RX_IN low for 2 cycles, then high -> START rejects the glitch at edge 7, state returns to IDLE, dat_samp_en drops, no flags set.
- Two frames 0x55 then 0xAA with zero idle gap -> two data_valid pulses, P_DATA=0x55 then 0xAA. A par_err set by an earlier bad frame clears on the next start.
- Assert RST mid-DATA (bit 4) -> all outputs 0 immediately (asynchronous). A following clean frame 0x0F is received correctly.
